lane_pattern_gen: RTL

LANE_PATTERN_GEN -- requirements
Module: lane_pattern_gen

---
 rtl/lane_pattern_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lane_pattern_gen.sv
// Lane pattern generator: fills a 16-bit lane row one bit per cycle from an LFSR,
// laying down fixed-length cars separated by forced gaps. Define PATTERN_MIRROR_EN for a bit-reversed (left-moving) option.
module lane_pattern_gen #(
  parameter int CAR_LEN = 3,
  parameter int GAP_MIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] seed,
  input  logic        seed_load,
  input  logic [1:0]  density,
`ifdef PATTERN_MIRROR_EN
  input  logic        dir,
`endif
  output logic [15:0] pattern,
  output logic        pattern_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    READY
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [3:0]  CAR_RUN_INIT = 4'(CAR_LEN - 1);
  localparam logic [3:0]  GAP_INIT     = 4'(GAP_MIN);

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [14:0] r_shift;
  logic [3:0]  r_bitCnt;
  logic [3:0]  r_run;
  logic [3:0]  r_gap;
  logic [1:0]  r_density;
  logic [15:0] r_pattern;
  logic        r_valid;
  logic        r_busy;
`ifdef PATTERN_MIRROR_EN
  logic        r_dir;
`endif

  logic [3:0]  w_thr;
  logic        w_bit;
  logic [3:0]  w_runNext;
  logic [3:0]  w_gapNext;
  logic [15:0] w_word;
  logic [15:0] w_final;
  logic [15:0] w_lfsrStep;
  logic [15:0] w_seedVal;

  always_comb begin
    unique case (r_density)
      2'd0:    w_thr = 4'd2;
      2'd1:    w_thr = 4'd4;
      2'd2:    w_thr = 4'd8;
      default: w_thr = 4'd12;
    endcase
  end

  // Bit priority: finish the running car, then the forced gap, then roll the LFSR.
  always_comb begin
    w_bit     = 1'b0;
    w_runNext = r_run;
    w_gapNext = r_gap;
    if (r_run != 4'd0) begin
      w_bit     = 1'b1;
      w_runNext = r_run - 4'd1;
      if (r_run == 4'd1) w_gapNext = GAP_INIT;
    end else if (r_gap != 4'd0) begin
      w_gapNext = r_gap - 4'd1;
    end else if (r_lfsr[3:0] < w_thr) begin
      w_bit     = 1'b1;
      w_runNext = CAR_RUN_INIT;
      if (CAR_RUN_INIT == 4'd0) w_gapNext = GAP_INIT;
    end
  end

  assign w_word = {r_shift, w_bit};

  always_comb begin
    logic [15:0] w_nonEmpty;
    w_nonEmpty = (w_word == 16'h0000) ? 16'h8000 : w_word;
    w_final    = w_nonEmpty;
`ifdef PATTERN_MIRROR_EN
    if (r_dir) begin
      for (int i = 0; i < 16; i++) w_final[i] = w_nonEmpty[15 - i];
    end
`endif
  end

  assign w_lfsrStep = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
  assign w_seedVal  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;

  // A seed load overrides the step but leaves the FSM and bit position untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_lfsr    <= LFSR_DEFAULT;
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_run     <= '0;
      r_gap     <= '0;
      r_density <= '0;
      r_pattern <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef PATTERN_MIRROR_EN
      r_dir     <= 1'b0;
`endif
    end else begin
      if (seed_load) begin
        r_lfsr <= w_seedVal;
      end else if (r_state == GEN) begin
        r_lfsr <= w_lfsrStep;
      end

      unique case (r_state)
        IDLE: begin
          r_state   <= GEN;
          r_busy    <= 1'b1;
          r_bitCnt  <= '0;
          r_run     <= '0;
          r_gap     <= '0;
          r_shift   <= '0;
          r_density <= density;
`ifdef PATTERN_MIRROR_EN
          r_dir     <= dir;
`endif
        end
        GEN: begin
          r_shift  <= w_word[14:0];
          r_run    <= w_runNext;
          r_gap    <= w_gapNext;
          r_bitCnt <= r_bitCnt + 4'd1;
          if (r_bitCnt == 4'd15) begin
            r_state   <= READY;
            r_pattern <= w_final;
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        READY: begin
          if (req) begin
            r_state   <= GEN;
            r_valid   <= 1'b0;
            r_busy    <= 1'b1;
            r_bitCnt  <= '0;
            r_run     <= '0;
            r_gap     <= '0;
            r_shift   <= '0;
            r_density <= density;
`ifdef PATTERN_MIRROR_EN
            r_dir     <= dir;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pattern       = r_pattern;
  assign pattern_valid = r_valid;
  assign busy          = r_busy;

endmodule
